// File: rtl/big2_pkg.sv
// Shared definitions for the Big 2 datapath: controller state encoding, move limit
// and width helpers used by the controller, comparator and hand updater.
package big2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL,
    ST_TURN,
    ST_COMPARE,
    ST_UPDATE,
    ST_CLEAR,
    ST_WIN
  } state_e;

  localparam int MAX_PLAY = 5;

  // Seat index width; a single seat bit is kept even for degenerate counts.
  function automatic int pw_of(input int num_players);
    return (num_players <= 2) ? 1 : $clog2(num_players);
  endfunction

  function automatic int cw_of(input int hand_size);
    return $clog2(hand_size + 1);
  endfunction

endpackage

// File: rtl/big2_hand_counters.sv
// Per-seat remaining-card counters: load all seats at once, decrement one seat,
// and read back one seat selected by index.
module big2_hand_counters #(
  parameter int NUM_PLAYERS = 2,
  parameter int CW          = 4,
  parameter int PW          = 1
) (
  input  logic          clka,
  input  logic          restart_n,
  input  logic          load_all,
  input  logic [CW-1:0] load_val,
  input  logic          dec_en,
  input  logic [PW-1:0] dec_idx,
  input  logic [CW-1:0] dec_amt,
  input  logic [PW-1:0] rd_idx,
  output logic [CW-1:0] rd_cnt
);

  logic [NUM_PLAYERS*CW-1:0] cnt_flat;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_seat
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (load_all) begin
        cnt_d = load_val;
      end else if (dec_en && (dec_idx == PW'(gi))) begin
        cnt_d = cnt_q - dec_amt;
      end
    end

    always_ff @(posedge clka) begin
      if (!restart_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_flat[gi*CW +: CW] = cnt_q;
  end

  // Unused seat codes read as zero rather than indexing past the array.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (rd_idx == PW'(i)) begin
        rd_cnt = cnt_flat[i*CW +: CW];
      end
    end
  end

endmodule

// File: rtl/big2_turn_ctrl.sv
// Big 2 game-flow controller for 2-4 seats: deals, validates moves, sequences the
// comparator and hand updater, tracks passes and clears the stack after a full round.
module big2_turn_ctrl #(
  parameter  int NUM_PLAYERS = 2,
  parameter  int HAND_SIZE   = 13,
  parameter  int MAX_PLAY    = big2_pkg::MAX_PLAY,
  localparam int PW          = big2_pkg::pw_of(NUM_PLAYERS),
  localparam int CW          = big2_pkg::cw_of(HAND_SIZE)
) (
  input  logic          clka,
  input  logic          RESTART_N,
  input  logic          START,
  input  logic          DEAL_DONE,
  input  logic [PW-1:0] FIRST_PLAYER,
  input  logic          MOVE_VALID,
  input  logic          MOVE_PASS,
  input  logic [2:0]    MOVE_CNT,
  output logic          MOVE_READY,
  output logic          MOVE_REJECT,
  output logic          CMP_REQ,
  input  logic          CMP_DONE,
  input  logic          CMP_LARGER,
  output logic          UPD_REQ,
  input  logic          UPD_DONE,
  output logic          DEAL_REQ,
  output logic          RESET_TOP,
  output logic [PW-1:0] CUR_PLAYER,
  output logic          FREE_LEAD,
  output logic          GAME_OVER,
  output logic [PW-1:0] WINNER
);
  import big2_pkg::*;

  localparam int XW = (CW > 3) ? CW : 3;

  state_e        state_q, state_d;
  logic [PW-1:0] cur_q, cur_d, leader_q, leader_d, pass_q, pass_d, winner_q, winner_d;
  logic          free_lead_q, free_lead_d;
  logic [2:0]    mv_cnt_q, mv_cnt_d;
  logic          ready_q, ready_d, reject_q, reject_d, cmp_req_q, cmp_req_d;
  logic          upd_req_q, upd_req_d, deal_req_q, deal_req_d;
  logic          reset_top_q, reset_top_d, game_over_q, game_over_d;

  logic [CW-1:0] rd_cnt;
  logic [XW-1:0] offer_ext, latched_ext, cnt_ext;
  logic          play_bad, move_bad, last_pass, upd_fire;

  big2_hand_counters #(
    .NUM_PLAYERS(NUM_PLAYERS),
    .CW         (CW),
    .PW         (PW)
  ) u_counters (
    .clka     (clka),
    .restart_n(RESTART_N),
    .load_all (state_q == ST_DEAL),
    .load_val (CW'(HAND_SIZE)),
    .dec_en   (upd_fire),
    .dec_idx  (cur_q),
    .dec_amt  (CW'(mv_cnt_q)),
    .rd_idx   (cur_q),
    .rd_cnt   (rd_cnt)
  );

  function automatic logic [PW-1:0] next_seat(input logic [PW-1:0] seat);
    return (seat == PW'(NUM_PLAYERS - 1)) ? '0 : seat + PW'(1);
  endfunction

  assign offer_ext   = XW'(MOVE_CNT);
  assign latched_ext = XW'(mv_cnt_q);
  assign cnt_ext     = XW'(rd_cnt);
  assign play_bad    = (offer_ext == '0) || (offer_ext > XW'(MAX_PLAY)) || (offer_ext > cnt_ext);
  assign move_bad    = MOVE_PASS ? free_lead_q : play_bad;
  assign last_pass   = (pass_q + PW'(1)) == PW'(NUM_PLAYERS - 1);
  assign upd_fire    = (state_q == ST_UPDATE) && UPD_DONE;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    leader_d    = leader_q;
    pass_d      = pass_q;
    winner_d    = winner_q;
    free_lead_d = free_lead_q;
    mv_cnt_d    = mv_cnt_q;
    reject_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (START) state_d = ST_DEAL;
      ST_DEAL: begin
        if (DEAL_DONE) begin
          state_d     = ST_TURN;
          cur_d       = FIRST_PLAYER;
          leader_d    = FIRST_PLAYER;
          free_lead_d = 1'b1;
          pass_d      = '0;
        end
      end
      ST_TURN: begin
        if (MOVE_VALID && ready_q) begin
          if (move_bad) begin
            reject_d = 1'b1;
          end else if (MOVE_PASS) begin
            pass_d = pass_q + PW'(1);
            if (last_pass) state_d = ST_CLEAR;
            else cur_d = next_seat(cur_q);
          end else begin
            mv_cnt_d = MOVE_CNT;
            state_d  = free_lead_q ? ST_UPDATE : ST_COMPARE;
          end
        end
      end
      ST_COMPARE: begin
        if (CMP_DONE) begin
          state_d  = CMP_LARGER ? ST_UPDATE : ST_TURN;
          reject_d = !CMP_LARGER;
        end
      end
      ST_UPDATE: begin
        if (UPD_DONE) begin
          leader_d    = cur_q;
          pass_d      = '0;
          free_lead_d = 1'b0;
          // The reject rule guarantees rd_cnt >= latched count, so equality means empty hand.
          if (cnt_ext == latched_ext) begin
            state_d  = ST_WIN;
            winner_d = cur_q;
          end else begin
            state_d = ST_TURN;
            cur_d   = next_seat(cur_q);
          end
        end
      end
      ST_CLEAR: begin
        state_d     = ST_TURN;
        cur_d       = leader_q;
        free_lead_d = 1'b1;
        pass_d      = '0;
      end
      ST_WIN: begin
        if (START) begin
          state_d     = ST_IDLE;
          free_lead_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Level outputs are registered copies of the next-state decode.
    ready_d     = (state_d == ST_TURN);
    cmp_req_d   = (state_d == ST_COMPARE);
    upd_req_d   = (state_d == ST_UPDATE);
    deal_req_d  = (state_d == ST_DEAL);
    reset_top_d = (state_d == ST_CLEAR);
    game_over_d = (state_d == ST_WIN);
  end

  always_ff @(posedge clka) begin
    if (!RESTART_N) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      leader_q    <= '0;
      pass_q      <= '0;
      winner_q    <= '0;
      free_lead_q <= 1'b0;
      mv_cnt_q    <= '0;
      ready_q     <= 1'b0;
      reject_q    <= 1'b0;
      cmp_req_q   <= 1'b0;
      upd_req_q   <= 1'b0;
      deal_req_q  <= 1'b0;
      reset_top_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      leader_q    <= leader_d;
      pass_q      <= pass_d;
      winner_q    <= winner_d;
      free_lead_q <= free_lead_d;
      mv_cnt_q    <= mv_cnt_d;
      ready_q     <= ready_d;
      reject_q    <= reject_d;
      cmp_req_q   <= cmp_req_d;
      upd_req_q   <= upd_req_d;
      deal_req_q  <= deal_req_d;
      reset_top_q <= reset_top_d;
      game_over_q <= game_over_d;
    end
  end

  assign MOVE_READY  = ready_q;
  assign MOVE_REJECT = reject_q;
  assign CMP_REQ     = cmp_req_q;
  assign UPD_REQ     = upd_req_q;
  assign DEAL_REQ    = deal_req_q;
  assign RESET_TOP   = reset_top_q;
  assign CUR_PLAYER  = cur_q;
  assign FREE_LEAD   = free_lead_q;
  assign GAME_OVER   = game_over_q;
  assign WINNER      = winner_q;

endmodule

// File: tb/tb_big2_turn_ctrl.sv
// Scoreboard bench for big2_turn_ctrl: a 2-seat/4-card instance and a 4-seat/13-card
// instance share stimulus; only the selected one is ever started.
module tb_big2_turn_ctrl;

  localparam int K_TURN = 0, K_REJ = 1, K_CMP = 2, K_UPD = 3, K_CLR = 4, K_WIN = 5, K_NONE = 7;

  logic       clk = 1'b0;
  logic       rst_n, start2, start4, deal_done;
  logic [1:0] first_player;
  logic       mv_valid, mv_pass;
  logic [2:0] mv_cnt;
  logic       cmp_done, cmp_larger, upd_done;

  logic       d2_ready, d2_reject, d2_cmp_req, d2_upd_req, d2_deal_req, d2_reset_top, d2_free, d2_over;
  logic [0:0] d2_cur, d2_winner;
  logic       d4_ready, d4_reject, d4_cmp_req, d4_upd_req, d4_deal_req, d4_reset_top, d4_free, d4_over;
  logic [1:0] d4_cur, d4_winner;

  big2_turn_ctrl #(.NUM_PLAYERS(2), .HAND_SIZE(4)) dut2 (
    .clka(clk), .RESTART_N(rst_n), .START(start2), .DEAL_DONE(deal_done),
    .FIRST_PLAYER(first_player[0]), .MOVE_VALID(mv_valid), .MOVE_PASS(mv_pass), .MOVE_CNT(mv_cnt),
    .MOVE_READY(d2_ready), .MOVE_REJECT(d2_reject), .CMP_REQ(d2_cmp_req), .CMP_DONE(cmp_done),
    .CMP_LARGER(cmp_larger), .UPD_REQ(d2_upd_req), .UPD_DONE(upd_done), .DEAL_REQ(d2_deal_req),
    .RESET_TOP(d2_reset_top), .CUR_PLAYER(d2_cur), .FREE_LEAD(d2_free), .GAME_OVER(d2_over),
    .WINNER(d2_winner));

  big2_turn_ctrl #(.NUM_PLAYERS(4), .HAND_SIZE(13)) dut4 (
    .clka(clk), .RESTART_N(rst_n), .START(start4), .DEAL_DONE(deal_done),
    .FIRST_PLAYER(first_player), .MOVE_VALID(mv_valid), .MOVE_PASS(mv_pass), .MOVE_CNT(mv_cnt),
    .MOVE_READY(d4_ready), .MOVE_REJECT(d4_reject), .CMP_REQ(d4_cmp_req), .CMP_DONE(cmp_done),
    .CMP_LARGER(cmp_larger), .UPD_REQ(d4_upd_req), .UPD_DONE(upd_done), .DEAL_REQ(d4_deal_req),
    .RESET_TOP(d4_reset_top), .CUR_PLAYER(d4_cur), .FREE_LEAD(d4_free), .GAME_OVER(d4_over),
    .WINNER(d4_winner));

  always #5 clk = ~clk;

  bit         sel4;
  logic       o_ready, o_reject, o_cmp_req, o_upd_req, o_deal_req, o_reset_top, o_free, o_over;
  logic [1:0] o_cur, o_winner;

  always_comb begin
    o_ready     = sel4 ? d4_ready     : d2_ready;
    o_reject    = sel4 ? d4_reject    : d2_reject;
    o_cmp_req   = sel4 ? d4_cmp_req   : d2_cmp_req;
    o_upd_req   = sel4 ? d4_upd_req   : d2_upd_req;
    o_deal_req  = sel4 ? d4_deal_req  : d2_deal_req;
    o_reset_top = sel4 ? d4_reset_top : d2_reset_top;
    o_free      = sel4 ? d4_free      : d2_free;
    o_over      = sel4 ? d4_over      : d2_over;
    o_cur       = sel4 ? d4_cur       : {1'b0, d2_cur};
    o_winner    = sel4 ? d4_winner    : {1'b0, d2_winner};
  end

  typedef struct {
    int kind;
    int player;
    int flag;
  } resp_t;

  resp_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_txn = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int obs_kind();
    if (o_over)      return K_WIN;
    if (o_reset_top) return K_CLR;
    if (o_upd_req)   return K_UPD;
    if (o_cmp_req)   return K_CMP;
    if (o_reject)    return K_REJ;
    if (o_ready)     return K_TURN;
    return K_NONE;
  endfunction

  task automatic push_exp(input int k, input int p, input int f);
    resp_t r;
    r.kind = k; r.player = p; r.flag = f;
    sb_q.push_back(r);
  endtask

  // Pops the oldest expectation and compares it with what the DUT shows now.
  task automatic check_resp(input string tag);
    resp_t r;
    int    k, p, f;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 0, 1);
      return;
    end
    r = sb_q.pop_front();
    k = obs_kind();
    p = (k == K_WIN) ? int'(o_winner) : int'(o_cur);
    f = (k == K_WIN) ? int'(o_over) : int'(o_free);
    n_txn++;
    $display("txn %0d %s: kind=%0d player=%0d flag=%0d (exp %0d/%0d/%0d)",
             n_txn, tag, k, p, f, r.kind, r.player, r.flag);
    check_val({tag, "_kind"}, k, r.kind);
    if (r.player >= 0) check_val({tag, "_player"}, p, r.player);
    if (r.flag >= 0)   check_val({tag, "_flag"}, f, r.flag);
  endtask

  task automatic wait_ready(input string tag);
    int waited = 0;
    while (!o_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!o_ready) check_val({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic do_move(input string tag, input bit pass, input int cnt,
                         input int ek, input int ep, input int ef);
    wait_ready(tag);
    mv_valid = 1'b1;
    mv_pass  = pass;
    mv_cnt   = 3'(cnt);
    push_exp(ek, ep, ef);
    tick();
    mv_valid = 1'b0;
    mv_pass  = 1'b0;
    check_resp(tag);
  endtask

  task automatic cmp_resp(input string tag, input bit larger, input int ek, input int ep, input int ef);
    cmp_done   = 1'b1;
    cmp_larger = larger;
    push_exp(ek, ep, ef);
    tick();
    cmp_done   = 1'b0;
    cmp_larger = 1'b0;
    check_resp(tag);
  endtask

  task automatic upd_resp(input string tag, input int ek, input int ep, input int ef);
    upd_done = 1'b1;
    push_exp(ek, ep, ef);
    tick();
    upd_done = 1'b0;
    check_resp(tag);
  endtask

  task automatic start_game(input string tag, input bit use4, input int first);
    sel4         = use4;
    first_player = 2'(first);
    if (use4) start4 = 1'b1; else start2 = 1'b1;
    tick();
    start2 = 1'b0;
    start4 = 1'b0;
    check_val({tag, "_deal_req"}, int'(o_deal_req), 1);
    deal_done = 1'b1;
    push_exp(K_TURN, first, 1);
    tick();
    deal_done = 1'b0;
    check_resp({tag, "_dealt"});
  endtask

  task automatic leave_win(input string tag);
    if (sel4) start4 = 1'b1; else start2 = 1'b1;
    tick();
    start2 = 1'b0;
    start4 = 1'b0;
    check_val({tag, "_over_cleared"}, int'(o_over), 0);
    check_val({tag, "_idle"}, obs_kind(), K_NONE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seat_plays[3] = '{5, 5, 3};
    rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0; deal_done = 1'b0; first_player = '0;
    mv_valid = 1'b0; mv_pass = 1'b0; mv_cnt = '0;
    cmp_done = 1'b0; cmp_larger = 1'b0; upd_done = 1'b0; sel4 = 1'b0;
    repeat (3) tick();
    check_val("rst_d2_ready", int'(d2_ready), 0);
    check_val("rst_d2_cur", int'(d2_cur), 0);
    check_val("rst_d4_deal", int'(d4_deal_req), 0);
    check_val("rst_d4_over", int'(d4_over), 0);
    check_val("rst_d4_free", int'(d4_free), 0);
    check_val("rst_d4_winner", int'(d4_winner), 0);
    rst_n = 1'b1;
    tick();

    // 2 seats, 4 cards: illegal offers on a free lead, then seat 1 plays out.
    start_game("g1", 1'b0, 1);
    do_move("g1_pass_free", 1'b1, 0, K_REJ, 1, 1);
    do_move("g1_cnt0", 1'b0, 0, K_REJ, 1, 1);
    do_move("g1_cnt6", 1'b0, 6, K_REJ, 1, 1);
    do_move("g1_cnt5_gt_hand", 1'b0, 5, K_REJ, 1, 1);
    do_move("g1_play4", 1'b0, 4, K_UPD, 1, 1);
    check_val("g1_no_cmp", int'(o_cmp_req), 0);
    upd_resp("g1_upd", K_WIN, 1, 1);
    leave_win("g1");

    // 2 seats: compare loss, single pass clears, then count-limit reject and win.
    start_game("g2", 1'b0, 0);
    do_move("g2_p0_play2", 1'b0, 2, K_UPD, 0, 1);
    upd_resp("g2_upd", K_TURN, 1, 0);
    do_move("g2_p1_play4", 1'b0, 4, K_CMP, 1, 0);
    cmp_resp("g2_cmp_small", 1'b0, K_REJ, 1, 0);
    do_move("g2_p1_pass", 1'b1, 0, K_CLR, -1, -1);
    push_exp(K_TURN, 0, 1);
    tick();
    check_resp("g2_after_clear");
    do_move("g2_p0_play3", 1'b0, 3, K_REJ, 0, 1);
    do_move("g2_p0_play2", 1'b0, 2, K_UPD, 0, 1);
    upd_resp("g2_upd_win", K_WIN, 0, 1);
    leave_win("g2");

    // 4 seats, 13 cards: full round of passes, wraparound, held compare, reset mid-game.
    start_game("g3", 1'b1, 2);
    do_move("g3_p2_play2", 1'b0, 2, K_UPD, 2, 1);
    upd_resp("g3_upd", K_TURN, 3, 0);
    do_move("g3_p3_pass", 1'b1, 0, K_TURN, 0, 0);
    do_move("g3_p0_pass", 1'b1, 0, K_TURN, 1, 0);
    do_move("g3_p1_pass", 1'b1, 0, K_CLR, -1, -1);
    push_exp(K_TURN, 2, 1);
    tick();
    check_resp("g3_after_clear");
    start4 = 1'b1;
    push_exp(K_TURN, 2, 1);
    tick();
    start4 = 1'b0;
    check_resp("g3_start_ignored");
    do_move("g3_p2_play1", 1'b0, 1, K_UPD, 2, 1);
    upd_resp("g3_upd2", K_TURN, 3, 0);
    do_move("g3_p3_play3", 1'b0, 3, K_CMP, 3, 0);
    mv_valid = 1'b1;
    upd_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_exp(K_CMP, 3, 0);
      tick();
      check_resp("g3_cmp_hold");
    end
    mv_valid = 1'b0;
    upd_done = 1'b0;
    cmp_resp("g3_cmp_large", 1'b1, K_UPD, 3, 0);
    upd_resp("g3_upd_wrap", K_TURN, 0, 0);
    do_move("g3_p0_play1", 1'b0, 1, K_CMP, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("g3_rst_cmp_req", int'(o_cmp_req), 0);
    check_val("g3_rst_ready", int'(o_ready), 0);
    check_val("g3_rst_over", int'(o_over), 0);
    check_val("g3_rst_cur", int'(o_cur), 0);

    // Seat 3 had 10 cards before the reset; surviving two 5-card plays proves the reload to 13.
    start_game("g4", 1'b1, 3);
    for (int k = 0; k < 3; k++) begin
      do_move("g4_p3_play", 1'b0, seat_plays[k], K_UPD, 3, 1);
      if (k < 2) begin
        upd_resp("g4_upd", K_TURN, 0, 0);
        do_move("g4_p0_pass", 1'b1, 0, K_TURN, 1, 0);
        do_move("g4_p1_pass", 1'b1, 0, K_TURN, 2, 0);
        do_move("g4_p2_pass", 1'b1, 0, K_CLR, -1, -1);
        push_exp(K_TURN, 3, 1);
        tick();
        check_resp("g4_after_clear");
      end else begin
        upd_resp("g4_upd_win", K_WIN, 3, 1);
      end
    end
    leave_win("g4");
    check_val("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
